fifo_sync: RTL and testbench

Single-clock, parametrised FIFO that extends the bare FIFO storage array with its own read/write pointers, full/empty/almost flags, an occupancy count and sticky overflow/underflow error flags. It supports two read modes: first-word-fall-through and registered read. It is the buffering stage between the UART receive/transmit paths and the ALU/register-file command logic wherever both sides share one clock. It replaces hand-built pointer logic around a raw memory.

---
 rtl/fifo_sync.sv | 119 +++++++++++
 tb/tb_fifo_sync.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered occupancy flags, sticky error flags and a
// selectable read mode (first-word-fall-through or one-cycle registered read).
module fifo_sync #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int ADDR      = $clog2(DEPTH),
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1,
  parameter int FWFT      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             clr_err,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ADDR:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [ADDR-1:0] PTR_LAST   = ADDR'(DEPTH - 1);
  localparam logic [ADDR:0]   CNT_FULL   = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0]   CNT_AFULL  = (ADDR+1)'(AFULL_TH);
  localparam logic [ADDR:0]   CNT_AEMPTY = (ADDR+1)'(AEMPTY_TH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR-1:0]  wr_ptr;
  logic [ADDR-1:0]  rd_ptr;
  logic [ADDR:0]    count_nxt;
  logic             wr_acc;
  logic             rd_acc;

  // Acceptance uses the registered flags, so a pop of the last word and a
  // push into an empty FIFO never see each other within the same cycle.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  function automatic logic [ADDR-1:0] ptr_inc(input logic [ADDR-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc) begin
      count_nxt = count + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= (CNT_AFULL == '0);
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count        <= count_nxt;
      full         <= (count_nxt == CNT_FULL);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= CNT_AFULL);
      almost_empty <= (count_nxt <= CNT_AEMPTY);
      // A new error event wins over a simultaneous clear.
      overflow     <= (overflow & ~clr_err) | (wr_en & full);
      underflow    <= (underflow & ~clr_err) | (rd_en & empty);
    end
  end

  // Storage is deliberately not reset; the pointers guard stale contents.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = empty ? '0 : mem[rd_ptr];
      assign rd_valid = ~empty;
    end else begin : g_reg
      logic [WIDTH-1:0] rd_q;
      logic             rd_v;

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_q <= '0;
          rd_v <= 1'b0;
        end else begin
          rd_v <= rd_acc;
          if (rd_acc) begin
            rd_q <= mem[rd_ptr];
          end
        end
      end

      assign rd_data  = rd_q;
      assign rd_valid = rd_v;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench: three fifo_sync instances (DEPTH=8 FWFT, DEPTH=5 FWFT,
// DEPTH=8 registered read) checked against per-instance expected-data queues.
module tb_fifo_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] q_c[$];
  logic [7:0] exp_d;

  // Instance A: DEPTH=8, FWFT=1
  logic       a_rst, a_wr_en, a_rd_en, a_clr;
  logic [7:0] a_wdata, a_rdata;
  logic       a_rv, a_full, a_empty, a_af, a_ae, a_ov, a_un;
  logic [3:0] a_count;

  // Instance B: DEPTH=5, FWFT=1
  logic       b_rst, b_wr_en, b_rd_en, b_clr;
  logic [7:0] b_wdata, b_rdata;
  logic       b_rv, b_full, b_empty, b_af, b_ae, b_ov, b_un;
  logic [3:0] b_count;

  // Instance C: DEPTH=8, FWFT=0
  logic       c_rst, c_wr_en, c_rd_en, c_clr;
  logic [7:0] c_wdata, c_rdata;
  logic       c_rv, c_full, c_empty, c_af, c_ae, c_ov, c_un;
  logic [3:0] c_count;

  fifo_sync #(.WIDTH(8), .DEPTH(8), .FWFT(1)) u_a (
    .clk(clk), .rst(a_rst), .wr_en(a_wr_en), .wr_data(a_wdata), .rd_en(a_rd_en),
    .clr_err(a_clr), .rd_data(a_rdata), .rd_valid(a_rv), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_count), .overflow(a_ov), .underflow(a_un)
  );

  fifo_sync #(.WIDTH(8), .DEPTH(5), .FWFT(1)) u_b (
    .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_data(b_wdata), .rd_en(b_rd_en),
    .clr_err(b_clr), .rd_data(b_rdata), .rd_valid(b_rv), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_count), .overflow(b_ov), .underflow(b_un)
  );

  fifo_sync #(.WIDTH(8), .DEPTH(8), .FWFT(0)) u_c (
    .clk(clk), .rst(c_rst), .wr_en(c_wr_en), .wr_data(c_wdata), .rd_en(c_rd_en),
    .clr_err(c_clr), .rd_data(c_rdata), .rd_valid(c_rv), .full(c_full), .empty(c_empty),
    .almost_full(c_af), .almost_empty(c_ae), .count(c_count), .overflow(c_ov), .underflow(c_un)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    tick();
    tick();
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    tick();
    total++; if (a_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", a_empty); end
    total++; if (a_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", a_count); end
    total++; if (a_ae !== 1'b1) begin bad++; $display("FAIL reset_aempty got=%b exp=1", a_ae); end
    total++; if (a_full !== 1'b0 || a_af !== 1'b0) begin bad++; $display("FAIL reset_full got=%b/%b exp=0/0", a_full, a_af); end
    total++; if (a_rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", a_rdata); end
    total++; if (a_ov !== 1'b0 || a_un !== 1'b0) begin bad++; $display("FAIL reset_err got=%b/%b exp=0/0", a_ov, a_un); end
    total++; if (c_rv !== 1'b0 || c_rdata !== 8'h00 || b_empty !== 1'b1) begin bad++; $display("FAIL reset_other got=%b/%h/%b exp=0/00/1", c_rv, c_rdata, b_empty); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      a_wr_en = 1'b1; a_wdata = 8'(i);
      q_a.push_back(8'(i));
      tick();
      total++; if (a_count !== 4'(i)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", a_count, i); end
      total++; if (a_af !== (i >= 7)) begin bad++; $display("FAIL fill_afull i=%0d got=%b exp=%b", i, a_af, (i >= 7)); end
      total++; if (a_full !== (i == 8)) begin bad++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, a_full, (i == 8)); end
    end
    a_wdata = 8'hFF;
    tick();
    a_wr_en = 1'b0;
    total++; if (a_ov !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", a_ov); end
    total++; if (a_count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", a_count); end
    for (int i = 0; i < 8; i++) begin
      exp_d = q_a.pop_front();
      total++; if (a_rdata !== exp_d) begin bad++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, a_rdata, exp_d); end
      a_rd_en = 1'b1;
      tick();
      a_rd_en = 1'b0;
    end
    total++; if (a_empty !== 1'b1 || a_count !== 4'd0) begin bad++; $display("FAIL drain_empty got=%b/%0d exp=1/0", a_empty, a_count); end
    total++; if (a_rdata !== 8'h00) begin bad++; $display("FAIL drain_rdata_zero got=%h exp=00", a_rdata); end
    total++; if (a_un !== 1'b0) begin bad++; $display("FAIL drain_unf got=%b exp=0", a_un); end
  endtask

  task automatic test_wrap();
    int v;
    int max_cnt;
    v = 8'h10;
    max_cnt = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) begin
        b_wr_en = 1'b1; b_wdata = 8'(v);
        q_b.push_back(8'(v));
        v++;
        tick();
        if (int'(b_count) > max_cnt) max_cnt = int'(b_count);
      end
      b_wr_en = 1'b0;
      total++; if (b_count !== 4'd3) begin bad++; $display("FAIL wrap_count r=%0d got=%0d exp=3", r, b_count); end
      for (int i = 0; i < 3; i++) begin
        exp_d = q_b.pop_front();
        total++; if (b_rdata !== exp_d) begin bad++; $display("FAIL wrap_data r=%0d got=%h exp=%h", r, b_rdata, exp_d); end
        b_rd_en = 1'b1;
        tick();
        b_rd_en = 1'b0;
      end
    end
    total++; if (max_cnt > 3) begin bad++; $display("FAIL wrap_maxcount got=%0d exp<=3", max_cnt); end
    total++; if (b_empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", b_empty); end
  endtask

  task automatic test_simultaneous();
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_wr_en = 1'b1; a_wdata = 8'(8'h30 + i);
      q_a.push_back(8'(8'h30 + i));
      tick();
    end
    a_wdata = 8'h77; a_rd_en = 1'b1;
    void'(q_a.pop_front());
    tick();
    a_wr_en = 1'b0; a_rd_en = 1'b0;
    total++; if (a_count !== 4'd7) begin bad++; $display("FAIL simul_full_count got=%0d exp=7", a_count); end
    total++; if (a_ov !== 1'b1 || a_full !== 1'b0) begin bad++; $display("FAIL simul_full_flags got=%b/%b exp=1/0", a_ov, a_full); end
    while (q_a.size() > 0) begin
      exp_d = q_a.pop_front();
      total++; if (a_rdata !== exp_d) begin bad++; $display("FAIL simul_drain got=%h exp=%h", a_rdata, exp_d); end
      a_rd_en = 1'b1;
      tick();
      a_rd_en = 1'b0;
    end
    a_wr_en = 1'b1; a_rd_en = 1'b1; a_wdata = 8'hAA;
    q_a.push_back(8'hAA);
    total++; if (a_rdata !== 8'h00) begin bad++; $display("FAIL simul_empty_pre got=%h exp=00", a_rdata); end
    tick();
    a_wr_en = 1'b0; a_rd_en = 1'b0;
    total++; if (a_count !== 4'd1 || a_un !== 1'b1) begin bad++; $display("FAIL simul_empty got=%0d/%b exp=1/1", a_count, a_un); end
    exp_d = q_a[0];
    total++; if (a_rdata !== exp_d) begin bad++; $display("FAIL simul_empty_data got=%h exp=%h", a_rdata, exp_d); end
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    total++; if (a_ov !== 1'b0 || a_un !== 1'b0) begin bad++; $display("FAIL clr_err got=%b/%b exp=0/0", a_ov, a_un); end
    // Clear and a fresh error in the same cycle must leave the flag set.
    a_clr = 1'b1; a_wr_en = 1'b0; a_rd_en = 1'b1;
    exp_d = q_a.pop_front();
    tick();
    a_rd_en = 1'b1;
    tick();
    a_clr = 1'b0; a_rd_en = 1'b0;
    total++; if (a_un !== 1'b1 || a_empty !== 1'b1) begin bad++; $display("FAIL clr_vs_event got=%b/%b exp=1/1", a_un, a_empty); end
  endtask

  task automatic test_fwft0();
    c_wr_en = 1'b1; c_wdata = 8'h5A; q_c.push_back(8'h5A);
    tick();
    c_wdata = 8'hC3; q_c.push_back(8'hC3);
    tick();
    c_wr_en = 1'b0;
    total++; if (c_rv !== 1'b0 || c_count !== 4'd2) begin bad++; $display("FAIL rr_idle got=%b/%0d exp=0/2", c_rv, c_count); end
    c_rd_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_d = q_c.pop_front();
      total++; if (c_rv !== 1'b1 || c_rdata !== exp_d) begin bad++; $display("FAIL rr_read i=%0d got=%b/%h exp=1/%h", i, c_rv, c_rdata, exp_d); end
    end
    c_rd_en = 1'b0;
    tick();
    total++; if (c_rv !== 1'b0 || c_rdata !== 8'hC3 || c_empty !== 1'b1) begin bad++; $display("FAIL rr_hold got=%b/%h/%b exp=0/c3/1", c_rv, c_rdata, c_empty); end
  endtask

  task automatic test_reset_mid();
    c_rd_en = 1'b1;
    tick();
    c_rd_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c_wr_en = 1'b1; c_wdata = 8'(8'hE0 + i);
      q_c.push_back(8'(8'hE0 + i));
      tick();
    end
    c_wr_en = 1'b0;
    total++; if (c_count !== 4'd4 || c_un !== 1'b1) begin bad++; $display("FAIL mid_pre got=%0d/%b exp=4/1", c_count, c_un); end
    c_rd_en = 1'b1; c_rst = 1'b1;
    q_c.delete();
    tick();
    c_rd_en = 1'b0; c_rst = 1'b0;
    total++; if (c_count !== 4'd0 || c_empty !== 1'b1) begin bad++; $display("FAIL mid_count got=%0d/%b exp=0/1", c_count, c_empty); end
    total++; if (c_rv !== 1'b0 || c_rdata !== 8'h00) begin bad++; $display("FAIL mid_read got=%b/%h exp=0/00", c_rv, c_rdata); end
    total++; if (c_ov !== 1'b0 || c_un !== 1'b0) begin bad++; $display("FAIL mid_err got=%b/%b exp=0/0", c_ov, c_un); end
    c_wr_en = 1'b1; c_wdata = 8'h99; q_c.push_back(8'h99);
    tick();
    c_wr_en = 1'b0; c_rd_en = 1'b1;
    tick();
    c_rd_en = 1'b0;
    exp_d = q_c.pop_front();
    total++; if (c_rv !== 1'b1 || c_rdata !== exp_d) begin bad++; $display("FAIL mid_after got=%b/%h exp=1/%h", c_rv, c_rdata, exp_d); end
  endtask

  initial begin
    a_rst = 1'b1; a_wr_en = 1'b0; a_rd_en = 1'b0; a_clr = 1'b0; a_wdata = 8'h00;
    b_rst = 1'b1; b_wr_en = 1'b0; b_rd_en = 1'b0; b_clr = 1'b0; b_wdata = 8'h00;
    c_rst = 1'b1; c_wr_en = 1'b0; c_rd_en = 1'b0; c_clr = 1'b0; c_wdata = 8'h00;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_fwft0();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
